apex7_ibt_scanner: RTL
======================

Name: apex7_ibt_scanner

Overview:
- Upstream stimulus sequencer for the apex7 next-state controller.
- Accepts a 6-bit CAT word over a valid/ready command handshake, pulses ICLR, then steps the IBT selector through all six CAT positions with WATCH asserted.
- Samples the controller's combinational ORWD_F response at each step, self-checks it, and returns a 6-bit result mask and an error flag over a valid/ready result handshake.

Parameters:
- DWELL, 2: cycles each IBT code is held; ORWD_F is sampled on the last of them. Legal range 1..15; 0 behaves as 1.
- DWELL_W, 4: width of the dwell counter.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  scanner idle, command accepted on VALID&READY
- CMD_CAT  in  6  CAT word to scan, bit k = CATk
- CAT  out  6  registered CAT drive to controller
- IBT  out  3  IBT2..IBT0 selector drive
- ICLR  out  1  one-cycle clear pulse to controller
- WATCH  out  1  WATCH drive to controller
- ORWD_F  in  1  controller response (combinational from CAT/IBT/WATCH)
- RES_VALID  out  1  result available
- RES_READY  in  1  result consumed on VALID&READY
- RES_MASK  out  6  sampled ORWD_F per CAT position
- RES_ERR  out  1  any response mismatch during the scan

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low, RST_N.
- Reset values: CMD_READY=1, CAT=0, IBT=000, ICLR=0, WATCH=0, RES_VALID=0, RES_MASK=0, RES_ERR=0, FSM=IDLE, dwell count=0, index k=0.
- All outputs are registered.
- FSM states: IDLE, CLEAR, GUARD, SCAN, DONE.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID: latch CMD_CAT into CAT, clear RES_MASK and RES_ERR, go to CLEAR.
- CLEAR (1 cycle): ICLR=1, WATCH=0, IBT=000, CMD_READY=0. Next state GUARD.
- GUARD (1 cycle):
  - ICLR=0, WATCH=0.
  - Sample ORWD_F; the required value is 1, since WATCH low forces ORWD_F high. A 0 sets the error flag.
  - Load k=0 and go to SCAN.
- SCAN:
  - IBT = k+2, giving 010, 011, 100, 101, 110, 111 for k=0..5; WATCH=1.
  - The dwell counter runs 0..DWELL-1. On the last dwell cycle, RES_MASK[k] <= ORWD_F.
  - Expected ORWD_F is CAT[k] (ORWD_F is low exactly when the selected CAT bit is 0). A mismatch sets the error flag.
  - If k=5, go to DONE; otherwise k increments and the dwell counter resets.
- DONE:
  - RES_VALID=1, WATCH=0, IBT=000. CAT, RES_MASK and RES_ERR are held stable.
  - On RES_READY, RES_VALID drops and the FSM returns to IDLE.
  - CAT clears to 0 on the same edge.
- Latency (acceptance edge = cycle 0):
  - ICLR high in cycle 1; GUARD in cycle 2.
  - SCAN occupies cycles 3..2+6*DWELL.
  - RES_VALID rises in cycle 3+6*DWELL, i.e. cycle 15 for DWELL=2.
- Boundary cases:
  - CMD_VALID outside IDLE is ignored (CMD_READY=0). No queuing.
  - RES_READY outside DONE is ignored.
  - RES_READY held high constantly: DONE lasts exactly one cycle. The earliest next command is accepted the cycle after return to IDLE, so no back-to-back accept on the DONE exit edge.
  - RES_VALID stalled indefinitely: outputs are held and no timeout applies.
  - Reset mid-scan: immediate return to reset values. The partial mask is discarded and no RES_VALID is issued.
  - DWELL=1: the sample is taken in the single cycle that IBT is presented.
  - CMD_CAT changes after acceptance: no effect.

Decomposition:
- Shared package apex7_pkg holds:
  - the state enum (IDLE, CLEAR, GUARD, SCAN, DONE);
  - NUM_CAT=6;
  - IBT_IDLE=3'b000;
  - IBT_BASE=3'd2;
  - the width constant for the index (3 bits).
- Sub-module apex7_dwell_cnt: a loadable DWELL_W counter with a last-cycle flag. It is natural because it is reused by other apex7 stimulus stages.
- Everything else lives in one FSM module.

Test Plan:
- Reset: RST_N low mid-cycle -> all outputs at reset values asynchronously; CMD_READY=1 after release.
- Basic scan, DWELL=2, controller model attached, CMD_CAT=6'b101010 -> ICLR pulse in cycle 1, IBT sequence 010..111 each held 2 cycles, RES_VALID in cycle 15, RES_MASK=101010, RES_ERR=0.
- Fault injection: force ORWD_F=0 during GUARD, CMD_CAT=6'b111111 -> RES_MASK=111111, RES_ERR=1. Second run, force ORWD_F=1 at k=3 with CMD_CAT=0 -> RES_MASK=001000, RES_ERR=1.
- Backpressure: RES_READY low for 10 cycles after RES_VALID -> RES_MASK, CAT and RES_VALID stable; CMD_VALID pulses during that window ignored; accept occurs only after RES_READY plus one idle cycle.
- Reset mid-operation: RST_N asserted in cycle 7 of a scan -> no RES_VALID. A new command CMD_CAT=6'b000001 after release yields RES_MASK=000001.
- DWELL=1 build, CMD_CAT=6'b110011 -> RES_VALID in cycle 9, RES_MASK=110011, each IBT code visible for exactly 1 cycle.

Source files
------------

// File: rtl/apex7_pkg.sv
// Shared types and constants for the apex7 stimulus stages.
package apex7_pkg;

    localparam int unsigned NUM_CAT = 6;
    localparam int unsigned IDX_W   = 3;

    localparam logic [2:0] IBT_IDLE = 3'b000;
    localparam logic [2:0] IBT_BASE = 3'd2;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGuard,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/apex7_dwell_cnt.sv
// Loadable dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle.
module apex7_dwell_cnt #(
    parameter int unsigned DWELL   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    // A dwell of 0 is treated as a single-cycle dwell.
    localparam int unsigned DwellEff = (DWELL == 0) ? 1 : DWELL;
    localparam logic [DWELL_W-1:0] LastVal = DWELL_W'(DwellEff - 1);

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LastVal);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apex7_ibt_scanner.sv
// Drives CAT/IBT/WATCH into the apex7 controller, samples ORWD_F per CAT position
// and returns the response mask plus a mismatch flag.
module apex7_ibt_scanner
    import apex7_pkg::*;
#(
    parameter int unsigned DWELL   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [NUM_CAT-1:0] CMD_CAT,
    output logic [NUM_CAT-1:0] CAT,
    output logic [2:0]         IBT,
    output logic               ICLR,
    output logic               WATCH,
    input  logic               ORWD_F,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [NUM_CAT-1:0] RES_MASK,
    output logic               RES_ERR
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CAT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [NUM_CAT-1:0] cat_q, cat_d;
    logic [NUM_CAT-1:0] mask_q, mask_d;
    logic [2:0]         ibt_q, ibt_d;
    logic               iclr_q, iclr_d;
    logic               watch_q, watch_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               dwell_last;

    apex7_dwell_cnt #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .load_i (state_q == StGuard),
        .en_i   (state_q == StScan),
        .last_o (dwell_last)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cat_d   = cat_q;
        mask_d  = mask_q;
        ibt_d   = ibt_q;
        iclr_d  = 1'b0;
        watch_d = watch_q;
        ready_d = ready_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    cat_d   = CMD_CAT;
                    mask_d  = '0;
                    err_d   = 1'b0;
                    ready_d = 1'b0;
                    iclr_d  = 1'b1;
                    watch_d = 1'b0;
                    ibt_d   = IBT_IDLE;
                    state_d = StClear;
                end
            end
            StClear: state_d = StGuard;
            StGuard: begin
                // WATCH is low here, so a healthy controller holds ORWD_F high.
                if (!ORWD_F) err_d = 1'b1;
                k_d     = '0;
                ibt_d   = IBT_BASE;
                watch_d = 1'b1;
                state_d = StScan;
            end
            StScan: begin
                if (dwell_last) begin
                    mask_d[k_q] = ORWD_F;
                    if (ORWD_F != cat_q[k_q]) err_d = 1'b1;
                    if (k_q == LastIdx) begin
                        valid_d = 1'b1;
                        watch_d = 1'b0;
                        ibt_d   = IBT_IDLE;
                        state_d = StDone;
                    end else begin
                        k_d   = k_q + IDX_W'(1);
                        ibt_d = IBT_BASE + k_q + 3'd1;
                    end
                end
            end
            StDone: begin
                if (RES_READY) begin
                    valid_d = 1'b0;
                    cat_d   = '0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            k_q     <= '0;
            cat_q   <= '0;
            mask_q  <= '0;
            ibt_q   <= IBT_IDLE;
            iclr_q  <= 1'b0;
            watch_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cat_q   <= cat_d;
            mask_q  <= mask_d;
            ibt_q   <= ibt_d;
            iclr_q  <= iclr_d;
            watch_q <= watch_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign CMD_READY = ready_q;
    assign CAT       = cat_q;
    assign IBT       = ibt_q;
    assign ICLR      = iclr_q;
    assign WATCH     = watch_q;
    assign RES_VALID = valid_q;
    assign RES_MASK  = mask_q;
    assign RES_ERR   = err_q;

endmodule
